approx_mul_err_monitor: RTL and testbench



---
 rtl/approx_mul_err_monitor.sv | 143 ++++++++++++++
 tb/tb_approx_mul_err_monitor.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mul_err_monitor.sv
// Error-statistics monitor for an 8x8 approximate multiplier: compares Out against IN1*IN2 over a run.
// Optional signed bias accumulator (sum_err, bias_ovf) enabled by defining ERR_MONITOR_BIAS_EN.
module approx_mul_err_monitor #(
  parameter int WIDTH     = 8,
  parameter int N_SAMPLES = 65536,
  parameter int ACC_W     = 48,
  parameter int CNT_W     = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       IN1,
  input  logic [WIDTH-1:0]       IN2,
  input  logic [2*WIDTH-1:0]     Out,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       sample_cnt,
  output logic [CNT_W-1:0]       err_cnt,
  output logic [ACC_W-1:0]       sum_sq_err,
  output logic [2*WIDTH-1:0]     max_abs_err,
`ifdef ERR_MONITOR_BIAS_EN
  output logic signed [ACC_W-1:0] sum_err,
  output logic                   bias_ovf,
`endif
  output logic                   acc_ovf
);

  localparam int PW  = 2 * WIDTH;
  localparam int SQW = 2 * PW;
  localparam int SW  = ((ACC_W > SQW) ? ACC_W : SQW) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t r_state, w_next;

  logic                 r_s1_vld, r_s2_vld;
  logic signed [PW:0]   r_s1_e;
  logic [SQW-1:0]       r_s2_sq;

  logic                 w_accept, w_last, w_start_run;
  logic [PW-1:0]        w_prod, w_abs;
  logic signed [PW:0]   w_e;
  logic [SQW-1:0]       w_sq;
  logic [SW-1:0]        w_sum_ext;
  logic                 w_sat;

  assign in_ready    = (r_state == S_RUN);
  assign busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done        = (r_state == S_DONE);
  assign w_accept    = in_valid && in_ready;
  assign w_last      = (sample_cnt == CNT_W'(N_SAMPLES - 1));
  assign w_start_run = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  assign w_prod = PW'(IN1) * PW'(IN2);
  assign w_e    = signed'({1'b0, Out}) - signed'({1'b0, w_prod});
  // |e| always fits PW bits: e ranges over [-(2^W-1)^2, 2^PW-1]
  assign w_abs  = r_s1_e[PW] ? PW'(-r_s1_e) : PW'(r_s1_e);
  assign w_sq   = SQW'(w_abs) * SQW'(w_abs);

  assign w_sum_ext = SW'(sum_sq_err) + SW'(r_s2_sq);
  assign w_sat     = |w_sum_ext[SW-1:ACC_W];

`ifdef ERR_MONITOR_BIAS_EN
  localparam int BW = ((ACC_W > PW + 1) ? ACC_W : PW + 1) + 1;
  logic signed [BW-1:0] w_bias;
  logic                 w_bias_ovf;
  assign w_bias     = BW'(sum_err) + BW'(r_s1_e);
  // in range only when every bit from ACC_W-1 upward equals the sign
  assign w_bias_ovf = !((&w_bias[BW-1:ACC_W-1]) || !(|w_bias[BW-1:ACC_W-1]));
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_accept && w_last) w_next = S_DRAIN;
      S_DRAIN: if (!r_s1_vld && !r_s2_vld) w_next = S_DONE;
      S_DONE:  if (start) w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_s1_vld    <= 1'b0;
      r_s2_vld    <= 1'b0;
      r_s1_e      <= '0;
      r_s2_sq     <= '0;
      sample_cnt  <= '0;
      err_cnt     <= '0;
      sum_sq_err  <= '0;
      max_abs_err <= '0;
      acc_ovf     <= 1'b0;
`ifdef ERR_MONITOR_BIAS_EN
      sum_err     <= '0;
      bias_ovf    <= 1'b0;
`endif
    end else begin
      r_state  <= w_next;
      r_s1_vld <= w_accept;
      r_s2_vld <= r_s1_vld;
      if (w_accept) r_s1_e  <= w_e;
      if (r_s1_vld) r_s2_sq <= w_sq;
      if (w_start_run) begin
        sample_cnt  <= '0;
        err_cnt     <= '0;
        sum_sq_err  <= '0;
        max_abs_err <= '0;
        acc_ovf     <= 1'b0;
`ifdef ERR_MONITOR_BIAS_EN
        sum_err     <= '0;
        bias_ovf    <= 1'b0;
`endif
      end else begin
        if (w_accept) sample_cnt <= sample_cnt + CNT_W'(1);
        if (r_s1_vld) begin
          if (r_s1_e != '0) err_cnt <= err_cnt + CNT_W'(1);
          if (w_abs > max_abs_err) max_abs_err <= w_abs;
`ifdef ERR_MONITOR_BIAS_EN
          if (w_bias_ovf) begin
            bias_ovf <= 1'b1;
            sum_err  <= w_bias[BW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
          end else begin
            sum_err  <= w_bias[ACC_W-1:0];
          end
`endif
        end
        if (r_s2_vld) begin
          if (w_sat) begin
            sum_sq_err <= '1;
            acc_ovf    <= 1'b1;
          end else begin
            sum_sq_err <= w_sum_ext[ACC_W-1:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// Directed checks of approx_mul_err_monitor: three instances (N=4, small accumulator N=2, full sweep).
module tb_approx_mul_err_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  IN1 = '0, IN2 = '0;
  logic [15:0] Out = '0;
  logic        start_d = 1'b0, start_s = 1'b0, start_e = 1'b0;

  logic        d_rdy, d_busy, d_done, d_ovf;
  logic [16:0] d_scnt, d_ecnt;
  logic [47:0] d_sum;
  logic [15:0] d_max;
  logic        s_rdy, s_busy, s_done, s_ovf;
  logic [16:0] s_scnt, s_ecnt;
  logic [7:0]  s_sum;
  logic [15:0] s_max;
  logic        e_rdy, e_busy, e_done, e_ovf;
  logic [16:0] e_scnt, e_ecnt;
  logic [47:0] e_sum;
  logic [15:0] e_max;
`ifdef ERR_MONITOR_BIAS_EN
  logic signed [47:0] d_serr, e_serr;
  logic signed [7:0]  s_serr;
  logic d_bovf, s_bovf, e_bovf;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  approx_mul_err_monitor #(.WIDTH(8), .N_SAMPLES(4), .ACC_W(48), .CNT_W(17)) u_dut (
    .clk(clk), .rst(rst), .start(start_d), .in_valid(in_valid), .in_ready(d_rdy),
    .IN1(IN1), .IN2(IN2), .Out(Out), .busy(d_busy), .done(d_done),
    .sample_cnt(d_scnt), .err_cnt(d_ecnt), .sum_sq_err(d_sum), .max_abs_err(d_max),
`ifdef ERR_MONITOR_BIAS_EN
    .sum_err(d_serr), .bias_ovf(d_bovf),
`endif
    .acc_ovf(d_ovf));

  approx_mul_err_monitor #(.WIDTH(8), .N_SAMPLES(2), .ACC_W(8), .CNT_W(17)) u_sat (
    .clk(clk), .rst(rst), .start(start_s), .in_valid(in_valid), .in_ready(s_rdy),
    .IN1(IN1), .IN2(IN2), .Out(Out), .busy(s_busy), .done(s_done),
    .sample_cnt(s_scnt), .err_cnt(s_ecnt), .sum_sq_err(s_sum), .max_abs_err(s_max),
`ifdef ERR_MONITOR_BIAS_EN
    .sum_err(s_serr), .bias_ovf(s_bovf),
`endif
    .acc_ovf(s_ovf));

  approx_mul_err_monitor #(.WIDTH(8), .N_SAMPLES(65536), .ACC_W(48), .CNT_W(17)) u_ex (
    .clk(clk), .rst(rst), .start(start_e), .in_valid(in_valid), .in_ready(e_rdy),
    .IN1(IN1), .IN2(IN2), .Out(Out), .busy(e_busy), .done(e_done),
    .sample_cnt(e_scnt), .err_cnt(e_ecnt), .sum_sq_err(e_sum), .max_abs_err(e_max),
`ifdef ERR_MONITOR_BIAS_EN
    .sum_err(e_serr), .bias_ovf(e_bovf),
`endif
    .acc_ovf(e_ovf));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input int a, input int b, input int o);
    in_valid = v;
    IN1 = 8'(a);
    IN2 = 8'(b);
    Out = 16'(o);
  endtask

  task automatic wait_done_d(input string tag);
    for (int k = 0; k < 10 && !d_done; k++) tick();
    check(tag, 64'(d_done), 64'd1);
  endtask

  int exp_err, exp_sum, p;

  initial begin
    // reset state
    tick(); tick();
    check("rst_ready", 64'(d_rdy), 0);
    check("rst_busy", 64'(d_busy), 0);
    check("rst_done", 64'(d_done), 0);
    check("rst_scnt", 64'(d_scnt), 0);
    check("rst_sum", 64'(d_sum), 0);
    check("rst_ovf", 64'(d_ovf), 0);
    rst = 1'b0;
    tick();

    // beats while idle are dropped
    beat(1, 1, 1, 5);
    tick(); tick();
    check("idle_drop_scnt", 64'(d_scnt), 0);
    check("idle_drop_busy", 64'(d_busy), 0);
    beat(0, 0, 0, 0);

    // exact beats, done timing
    start_d = 1'b1; tick(); start_d = 1'b0;
    check("runA_busy", 64'(d_busy), 1);
    beat(1, 3, 5, 15);     tick();
    beat(1, 0, 0, 0);      tick();
    beat(1, 255, 255, 65025); tick();
    beat(1, 1, 1, 1);      tick();
    beat(0, 0, 0, 0);
    check("A_drain_ready", 64'(d_rdy), 0);
    check("A_drain_busy", 64'(d_busy), 1);
    tick(); check("A_done_t1", 64'(d_done), 0);
    tick(); check("A_done_t2", 64'(d_done), 0);
    tick(); check("A_done_t3", 64'(d_done), 1);
    check("A_busy", 64'(d_busy), 0);
    check("A_scnt", 64'(d_scnt), 4);
    check("A_ecnt", 64'(d_ecnt), 0);
    check("A_sum", 64'(d_sum), 0);
    check("A_max", 64'(d_max), 0);

    // error beats with latency checks: e=+2, e=-4
    start_d = 1'b1; tick(); start_d = 1'b0;
    check("B_done_clr", 64'(d_done), 0);
    check("B_scnt_clr", 64'(d_scnt), 0);
    beat(1, 3, 5, 17);   tick();
    check("B_scnt1", 64'(d_scnt), 1);
    check("B_ecnt_lat", 64'(d_ecnt), 0);
    beat(1, 10, 10, 96); tick();
    check("B_ecnt1", 64'(d_ecnt), 1);
    check("B_max1", 64'(d_max), 2);
    check("B_sum_lat", 64'(d_sum), 0);
    beat(1, 0, 0, 0);    tick();
    check("B_sum1", 64'(d_sum), 4);
    beat(1, 7, 7, 49);   tick();
    beat(0, 0, 0, 0);
    wait_done_d("B_done");
    check("B_scnt", 64'(d_scnt), 4);
    check("B_ecnt", 64'(d_ecnt), 2);
    check("B_sum", 64'(d_sum), 20);
    check("B_max", 64'(d_max), 4);
`ifdef ERR_MONITOR_BIAS_EN
    check("B_sum_err", 64'(d_serr), 64'hFFFF_FFFF_FFFF_FFFE);
    check("B_bias_ovf", 64'(d_bovf), 0);
`endif

    // gapped valid, then extra bad beats after the fourth accept
    start_d = 1'b1; tick(); start_d = 1'b0;
    for (int i = 0; i < 8; i++) begin
      beat((i % 2) == 0, 2, 3, 6);
      tick();
      if (i == 6) check("C_ready_after4", 64'(d_rdy), 0);
    end
    beat(1, 2, 3, 0);
    wait_done_d("C_done");
    check("C_ready_done", 64'(d_rdy), 0);
    check("C_scnt", 64'(d_scnt), 4);
    check("C_ecnt", 64'(d_ecnt), 0);
    check("C_sum", 64'(d_sum), 0);
    beat(0, 0, 0, 0);
    tick();

    // saturation on 8-bit accumulator: squares 144 + 144
    start_s = 1'b1; tick(); start_s = 1'b0;
    beat(1, 0, 0, 12);  tick();
    beat(1, 2, 6, 0);   tick();
    beat(0, 0, 0, 0);
    tick();
    check("S_sum1", 64'(s_sum), 144);
    check("S_ovf1", 64'(s_ovf), 0);
    tick();
    check("S_sum_sat", 64'(s_sum), 255);
    check("S_ovf_sat", 64'(s_ovf), 1);
    check("S_max", 64'(s_max), 12);
    tick();
    check("S_done", 64'(s_done), 1);
    start_s = 1'b1; tick(); start_s = 1'b0;
    check("S_sum_clr", 64'(s_sum), 0);
    check("S_ovf_clr", 64'(s_ovf), 0);

    // async reset with two beats in flight, each beat off by +1
    start_e = 1'b1; tick(); start_e = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      beat(1, i, i, i * i + 1);
      tick();
    end
    check("R_scnt_pre", 64'(e_scnt), 5);
    check("R_ecnt_pre", 64'(e_ecnt), 4);
    check("R_sum_pre", 64'(e_sum), 3);
    rst = 1'b1;
    #1;
    check("R_scnt", 64'(e_scnt), 0);
    check("R_ecnt", 64'(e_ecnt), 0);
    check("R_sum", 64'(e_sum), 0);
    check("R_max", 64'(e_max), 0);
    check("R_busy", 64'(e_busy), 0);
    check("R_ready", 64'(e_rdy), 0);
    beat(0, 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();
    start_e = 1'b1; tick(); start_e = 1'b0;
    beat(1, 4, 4, 16); tick();
    beat(0, 0, 0, 0);
    check("R2_scnt", 64'(e_scnt), 1);
    tick(); tick();
    check("R2_ecnt", 64'(e_ecnt), 0);
    check("R2_sum", 64'(e_sum), 0);

    // full sweep; the model multiplier truncates the two product LSBs
    rst = 1'b1; tick(); rst = 1'b0; tick();
    start_e = 1'b1; tick(); start_e = 1'b0;
    exp_err = 0;
    exp_sum = 0;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        p = a * b;
        if ((p & 3) != 0) exp_err++;
        exp_sum += (p & 3) * (p & 3);
        beat(1, a, b, p & 16'hFFFC);
        tick();
      end
    end
    beat(0, 0, 0, 0);
    for (int k = 0; k < 10 && !e_done; k++) tick();
    check("X_done", 64'(e_done), 1);
    check("X_busy", 64'(e_busy), 0);
    check("X_scnt", 64'(e_scnt), 65536);
    check("X_ecnt", 64'(e_ecnt), 64'(exp_err));
    check("X_sum", 64'(e_sum), 64'(exp_sum));
    check("X_max", 64'(e_max), 3);
    check("X_ovf", 64'(e_ovf), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
